program_fetch: RTL
==================

// Module: program_fetch
// PURPOSE
//   Reader side of the 16x32 program store. Walks a PC through the store and
//   drives its address (a) and read-enable (ld), capturing the returned word
//   from the shared d bus. Hands each instruction to the VDP core over a
//   valid/ready handshake. Decodes HALT and JUMP itself. Stalls while the
//   loader is writing the store.
// PARAMETERS
//   DW        32     instruction / data-bus width
//   AW        4      address width (store depth 2**AW)
//   HALT_OP   4'hF   opcode in instr[DW-1:DW-4] that ends the program
//   JUMP_OP   4'hE   opcode that sets PC to instr[AW-1:0]
//   WRAP      1      1: PC wraps (2**AW-1)->0; 0: after last address -> DONE
//   MAX_STEPS 64     instruction-handshake budget before forced stop (runaway guard)
// PORTS
//   c            in   1    clock, all state on rising edge
//   rst_n        in   1    asynchronous active-low reset
//   start        in   1    begin fetching at start_addr (sampled only in IDLE)
//   start_addr   in   AW   first PC value
//   abort        in   1    return to IDLE next edge, no done pulse
//   wr_busy      in   1    loader is writing the store; fetch must not read
//   a            out  AW   store address (= pc)
//   ld           out  1    store read enable; d is valid only while ld=1
//   d            in   DW   store read data (high-Z when ld=0)
//   instr        out  DW   captured instruction
//   instr_valid  out  1    instr presented to core
//   instr_ready  in   1    core accepts instr when valid&ready
//   pc           out  AW   current program counter
//   busy         out  1    state != IDLE
//   done         out  1    one-cycle pulse on normal end or on overrun
//   overrun      out  1    sticky; set when MAX_STEPS exhausted, cleared by start
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, pc=0, a=0, ld=0, instr=0, instr_valid=0,
//     done=0, overrun=0, step count=0. Deassertion takes effect on the next edge.
//   States: IDLE, READ, VALID, DONE.
//   IDLE:  start=1 -> pc<=start_addr, steps<=0, overrun<=0, go READ.
//   READ:  ld = ~wr_busy (combinational), a=pc. On an edge with ld=1:
//          instr<=d, go VALID. With wr_busy=1: remain in READ, ld=0, no capture.
//   VALID: instr_valid=1, instr held stable until the handshake. On valid&ready:
//          steps<=steps+1, then, in priority order:
//          - steps+1==MAX_STEPS -> overrun<=1, go DONE
//          - opcode==HALT_OP -> go DONE (pc unchanged)
//          - opcode==JUMP_OP -> pc<=instr[AW-1:0], go READ
//          - otherwise: pc==2**AW-1 and WRAP=0 -> go DONE; else pc<=pc+1
//            (mod 2**AW), go READ.
//   DONE:  done=1 for exactly this cycle, then IDLE.
//   instr_valid is low in every state except VALID. ld is low in every state
//     except READ.
//   Latency: start at edge N -> ld high in cycle N+1 -> instr_valid high in
//     cycle N+2. Peak rate is one instruction per 2 cycles.
//   abort has priority over all transitions. Next edge: state=IDLE,
//     instr_valid=0, ld=0, done stays 0. pc and overrun are held.
//   start outside IDLE is ignored. Simultaneous start and abort in IDLE: abort wins.
//   wr_busy rising while in VALID does not disturb the held instr.
//   Reset asserted mid-fetch: every output returns to its reset value immediately.
// TESTING
//   1 store={0:32'h1000_0001, 1:32'h2000_0002, 2:32'hF000_0000}, start, start_addr=0,
//     ready=1 -> instr 10000001, 20000002, F0000000 on alternate cycles;
//     done pulses once; busy drops.
//   2 JUMP: store[3]=32'hE000_0007, store[7]=HALT, start_addr=3 -> pc sequence 3,7;
//     done. Also loop store[5]=E0000005 -> overrun=1 after 64 handshakes.
//   3 Backpressure: instr_ready=0 for 5 cycles -> instr_valid and instr stable;
//     pc unchanged; ld=0 throughout.
//   4 wr_busy=1 for 3 cycles during READ -> ld=0 and no capture;
//     read completes on the first cycle with wr_busy=0.
//   5 WRAP=0, start_addr=15, non-halt word -> done after one instruction.
//     WRAP=1 -> pc goes 15->0.
//   6 abort in VALID -> IDLE next edge, instr_valid=0, no done.
//     rst_n low mid-READ -> all outputs at reset values immediately.

Source files
------------

// File: rtl/program_fetch.sv
// Program-store reader: walks a PC through the store, captures each word from the
// shared d bus and hands it to the VDP core over valid/ready, decoding HALT/JUMP locally.
module program_fetch #(
    parameter int       DW        = 32,
    parameter int       AW        = 4,
    parameter bit [3:0] HALT_OP   = 4'hF,
    parameter bit [3:0] JUMP_OP   = 4'hE,
    parameter bit       WRAP      = 1'b1,
    parameter int       MAX_STEPS = 64
) (
    input  logic          c,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          abort,
    input  logic          wr_busy,
    output logic [AW-1:0] a,
    output logic          ld,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    localparam int SW = $clog2(MAX_STEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_VALID, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic [DW-1:0] r_instr;
    logic [SW-1:0] r_steps, w_steps_nxt;
    logic          r_overrun, w_overrun_nxt;
    logic          w_capture;
    logic [SW-1:0] w_steps_inc;
    logic [3:0]    w_opcode;

    assign w_steps_inc = r_steps + SW'(1);
    assign w_opcode    = r_instr[DW-1 -: 4];

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_steps_nxt   = r_steps;
        w_overrun_nxt = r_overrun;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pc_nxt      = start_addr;
                    w_steps_nxt   = '0;
                    w_overrun_nxt = 1'b0;
                    w_state_nxt   = S_READ;
                end
            end
            S_READ: begin
                // The loader owns the store while wr_busy is high; wait it out.
                if (!wr_busy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (instr_ready) begin
                    w_steps_nxt = w_steps_inc;
                    if (w_steps_inc == SW'(MAX_STEPS)) begin
                        w_overrun_nxt = 1'b1;
                        w_state_nxt   = S_DONE;
                    end else if (w_opcode == HALT_OP) begin
                        w_state_nxt = S_DONE;
                    end else if (w_opcode == JUMP_OP) begin
                        w_pc_nxt    = r_instr[AW-1:0];
                        w_state_nxt = S_READ;
                    end else if (r_pc == {AW{1'b1}} && !WRAP) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_pc_nxt    = r_pc + AW'(1);
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // abort overrides everything, keeping pc and overrun as they were
        if (abort) begin
            w_state_nxt   = S_IDLE;
            w_pc_nxt      = r_pc;
            w_steps_nxt   = r_steps;
            w_overrun_nxt = r_overrun;
            w_capture     = 1'b0;
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_instr   <= '0;
            r_steps   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_steps   <= w_steps_nxt;
            r_overrun <= w_overrun_nxt;
            if (w_capture) r_instr <= d;
        end
    end

    assign a           = r_pc;
    assign pc          = r_pc;
    assign ld          = (r_state == S_READ) && !wr_busy;
    assign instr       = r_instr;
    assign instr_valid = (r_state == S_VALID);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign overrun     = r_overrun;

endmodule
